// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier I/O slice:
// default operand width, product width and the sequencer state type.
package spm_pkg;

   localparam int SPM_N      = 8;
   localparam int SPM_PROD_W = 2 * SPM_N;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SHIFT,
      HOLD
   } spm_io_state_t;

endpackage

// File: rtl/spm_shift_reg.sv
// Generic right-shifting register used both as the Y serializer
// (MSB replicated on shift) and as the product deserializer
// (serial bit inserted at the MSB on shift).
module spm_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic         shift,
   input  logic         sign_rep,
   input  logic         ser_in,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] q
);

   // Clear wins over load, load wins over shift; a shift brings in either
   // a copy of the current MSB (arithmetic) or the serial input bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {(sign_rep ? q[W-1] : ser_in), q[W-1:1]};
      end
   end

endmodule

// File: rtl/spm_serial_io.sv
// Bit-serial I/O sequencer for the signed serial-parallel multiplier.
// Accepts a parallel Y operand, streams it LSB-first (sign-extended to
// 2N bits) into the SPM, gathers the serial product and presents it.
module spm_serial_io
   import spm_pkg::*;
#(
   parameter int N     = SPM_N,
   parameter int CNT_W = $clog2(2 * N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_y,
   output logic           spm_clr,
   output logic           spm_en,
   output logic           spm_y_bit,
   input  logic           spm_p_bit,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_product,
   output logic           busy
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(2 * N - 1);

   spm_io_state_t    state;
   logic [CNT_W-1:0] bit_cnt;
   logic [N-1:0]     y_q;
   logic [2*N-1:0]   p_q;
   logic             accept;
   logic             shifting;

   assign accept   = (state == IDLE) && in_valid;
   assign shifting = (state == SHIFT);

   // The Y register only feeds the SPM while shifting, so gate it to keep
   // the serial line quiet outside an operation.
   assign spm_y_bit   = spm_en & y_q[0];
   assign out_product = p_q;

   spm_shift_reg #(.W(N)) u_y_ser (
      .clk      (clk),
      .reset    (reset),
      .clr      (1'b0),
      .load     (accept),
      .shift    (shifting),
      .sign_rep (1'b1),
      .ser_in   (1'b0),
      .load_val (in_y),
      .q        (y_q)
   );

   spm_shift_reg #(.W(2 * N)) u_p_deser (
      .clk      (clk),
      .reset    (reset),
      .clr      (state == CLEAR),
      .load     (1'b0),
      .shift    (shifting),
      .sign_rep (1'b0),
      .ser_in   (spm_p_bit),
      .load_val ('0),
      .q        (p_q)
   );

   // Sequencer: state, bit counter and all handshake/SPM controls are
   // registered together so each output follows the state it belongs to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         in_ready  <= 1'b1;
         spm_clr   <= 1'b0;
         spm_en    <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= CLEAR;
                  in_ready <= 1'b0;
                  spm_clr  <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            CLEAR: begin
               state   <= SHIFT;
               bit_cnt <= '0;
               spm_clr <= 1'b0;
               spm_en  <= 1'b1;
            end
            SHIFT: begin
               if (bit_cnt == LAST_BIT) begin
                  state     <= HOLD;
                  bit_cnt   <= '0;
                  spm_en    <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spm_serial_io.sv
// Self-checking bench for spm_serial_io with a behavioural serial-parallel
// multiplier attached and a scoreboard of expected products and Y streams.
module tb_spm_serial_io;
   import spm_pkg::*;

   localparam int N  = SPM_N;
   localparam int PW = SPM_PROD_W;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_y;
   logic          spm_clr;
   logic          spm_en;
   logic          spm_y_bit;
   logic          spm_p_bit;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_product;
   logic          busy;

   int vectors     = 0;
   int miscompares = 0;

   logic [PW-1:0] prodq[$];
   logic [N-1:0]  yq[$];

   // Parallel multiplicand held by the SPM model
   logic [N-1:0]  x;

   spm_serial_io dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_y        (in_y),
      .spm_clr     (spm_clr),
      .spm_en      (spm_en),
      .spm_y_bit   (spm_y_bit),
      .spm_p_bit   (spm_p_bit),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Behavioural SPM: add x (sign-extended) when the Y bit is set, emit the
   // LSB of the running sum, then shift the sum right arithmetically.
   logic signed [31:0] acc;
   logic signed [31:0] sum;

   always_comb begin
      sum = acc + (spm_y_bit ? {{(32-N){x[N-1]}}, x} : 32'sd0);
   end

   assign spm_p_bit = sum[0];

   always @(posedge clk or posedge reset) begin
      if (reset)        acc <= 32'sd0;
      else if (spm_clr) acc <= 32'sd0;
      else if (spm_en)  acc <= sum >>> 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Monitor: Y-bit stream, latency, product scoreboard and idle gap
   int            cyc = 0;
   int            en_cnt = 0;
   int            lat = 0;
   int            hs_cyc = 0;
   bit            active = 1'b0;
   bit            armed = 1'b0;
   bit            gap_check = 1'b0;
   logic [N-1:0]  ycur;
   logic [PW-1:0] yext = '0;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         active = 1'b0;
         en_cnt = 0;
         armed  = 1'b0;
      end else begin
         if (spm_clr) begin
            if (yq.size() == 0) begin
               checkOutput("unexpected_clr", 32'd1, 32'd0);
            end else begin
               ycur = yq.pop_front();
               yext = {{N{ycur[N-1]}}, ycur};
            end
            checkOutput("clr_ready_busy", {30'd0, in_ready, busy}, 32'd1);
            en_cnt = 0;
            lat    = 0;
            active = 1'b1;
         end else if (active) begin
            lat++;
            if (out_valid) begin
               checkOutput("latency", lat, 32'd17);
               checkOutput("en_count", en_cnt, 32'd16);
               active = 1'b0;
            end
         end
         if (spm_en) begin
            if (en_cnt < PW) checkOutput("ybit", {31'd0, spm_y_bit}, {31'd0, yext[en_cnt]});
            else             checkOutput("en_overrun", 32'd1, 32'd0);
            en_cnt++;
         end
         if (out_valid && out_ready) begin
            hs_cyc = cyc;
            armed  = gap_check;
            if (prodq.size() == 0) checkOutput("unexpected_out", 32'd1, 32'd0);
            else                   checkOutput("product", out_product, prodq.pop_front());
         end
         if (in_valid && in_ready && armed) begin
            checkOutput("idle_gap", cyc - hs_cyc, 32'd1);
            armed = 1'b0;
         end
      end
   end

   task automatic checkResetOutputs();
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_spm_en", {31'd0, spm_en}, 32'd0);
      checkOutput("rst_spm_clr", {31'd0, spm_clr}, 32'd0);
      checkOutput("rst_y_bit", {31'd0, spm_y_bit}, 32'd0);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_product", out_product, 32'd0);
   endtask

   // Offer one operand, wait for acceptance and record the expectations
   task automatic applyStimulus(input logic [N-1:0] xv, input logic [N-1:0] yv);
      int n;
      logic signed [PW-1:0] p;
      x        = xv;
      in_y     = yv;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
      end else begin
         p = $signed(xv) * $signed(yv);
         prodq.push_back(p);
         yq.push_back(yv);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while ((prodq.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_y      = '0;
      out_ready = 1'b1;
      x         = '0;
      #3;
      checkResetOutputs();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] basic positive product");
      applyStimulus(8'h05, 8'h03);
      waitDone();

      $display("[TB] negative extremes");
      applyStimulus(8'h80, 8'h80);
      waitDone();
      applyStimulus(8'h7F, 8'hFF);
      waitDone();

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(8'h05, 8'h03);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) checkOutput("valid_timeout", 32'd0, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = i[0];
         in_y     = 8'hA5;
         @(negedge clk);
         checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("bp_product", out_product, 32'h000F);
         checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      checkOutput("bp_idle_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("bp_idle_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("bp_idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("bp_hold_product", out_product, 32'h000F);
      @(negedge clk);

      $display("[TB] reset mid-shift");
      applyStimulus(8'h05, 8'h7B);
      n = 0;
      while (n < 6) begin
         @(negedge clk);
         if (spm_en) n++;
      end
      #2 reset = 1'b1;
      #1;
      checkResetOutputs();
      prodq.delete();
      yq.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      applyStimulus(8'h05, 8'h02);
      waitDone();

      $display("[TB] back-to-back");
      gap_check = 1'b1;
      applyStimulus(8'h05, 8'h03);
      applyStimulus(8'h05, 8'hFD);
      waitDone();
      gap_check = 1'b0;
      if (prodq.size() != 0) checkOutput("leftover", prodq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
